// File: rtl/genius_pkg.sv
// Shared definitions for the genius game datapath and its input conditioning.
// The key conditioner reads its default key count and debounce length from here.
package genius_pkg;

  // Four board push-buttons
  localparam int N_KEYS_DEF   = 4;

  // 10 ms at 50 MHz
  localparam int DEBOUNCE_DEF = 500000;

  // Encoded index of one board key
  typedef logic [1:0] key_code_t;

endpackage

// File: rtl/key_debounce_cell.sv
// One push-button path: 2-FF synchroniser on the inverted raw KEY bit,
// followed by a debounce counter and the debounced "stable" flop.
// The synchroniser is cleared by the raw board reset so that it starts
// sampling the pin on the first edge after reset release. The counter and
// stable flop use the synchronised design reset.
module key_debounce_cell
  import genius_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic raw_rst_n,
  input  logic rst_n,
  input  logic key_n,
  output logic stable,
  output logic stable_next
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic stable_q, stable_d;

  // Synchroniser next values: invert so that 1 means "button held"
  always_comb begin
    sync1_d = ~key_n;
    sync2_d = sync1_q;
  end

  // Two-stage synchroniser for the asynchronous pin
  always_ff @(posedge clk or negedge raw_rst_n) begin
    if (!raw_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // Debounce: count cycles the synchronised level differs from stable,
  // accept the new level after DEBOUNCE_CYCLES consecutive differing cycles
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter and debounced level registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable      = stable_q;
  assign stable_next = stable_d;

endmodule

// File: rtl/key_input_conditioner.sv
// Conditions the active-low board push-buttons into clean, encoded press
// events for the game datapath. Each key is synchronised and debounced in a
// key_debounce_cell; this level performs the single-key check, encodes the
// pressed index and registers the event.
//
// Optional feature: define KEY_PRESS_LATCH_EN to hold each event until the
// consumer acknowledges it with press_ack. Without it, press_valid is a
// one-cycle pulse and press_ack is ignored.
module key_input_conditioner
  import genius_pkg::*;
#(
  parameter int N_KEYS          = N_KEYS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic                      CLOCK_50,
  input  logic                      reset_n,
  input  logic [N_KEYS-1:0]         KEY,
  input  logic                      enable,
  input  logic                      press_ack,
  output logic                      press_valid,
  output logic [$clog2(N_KEYS)-1:0] press_code,
  output logic [N_KEYS-1:0]         key_stable,
  output logic                      multi_err
);

  localparam int CODE_W = $clog2(N_KEYS);
  localparam int HELD_W = $clog2(N_KEYS + 1);

  logic [1:0]        rst_sync_q, rst_sync_d;
  logic              rst_int_n;
  logic [N_KEYS-1:0] stable_now;
  logic [N_KEYS-1:0] stable_next;
  logic [N_KEYS-1:0] rise;
  logic [HELD_W-1:0] held_count;
  logic [CODE_W-1:0] rise_code;
  logic              any_rise;
  logic              press_ok;
  logic              press_bad;

  logic              valid_q, valid_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              err_q, err_d;

  // Reset synchroniser shift: asserts with reset_n, releases two edges later
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Reset synchroniser register
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_int_n = rst_sync_q[1];

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk        (CLOCK_50),
      .raw_rst_n  (reset_n),
      .rst_n      (rst_int_n),
      .key_n      (KEY[g]),
      .stable     (stable_now[g]),
      .stable_next(stable_next[g])
    );
  end

  // Press qualification on next-state levels: a rise is a clean press only
  // when it is the single key that will be held after this edge
  always_comb begin
    rise       = stable_next & ~stable_now;
    held_count = '0;
    rise_code  = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      held_count = held_count + HELD_W'(stable_next[i]);
      if (rise[i]) begin
        rise_code = CODE_W'(i);
      end
    end
    any_rise  = |rise;
    press_ok  = enable && any_rise && (held_count == HELD_W'(1));
    press_bad = enable && any_rise && (held_count != HELD_W'(1));
  end

`ifdef KEY_PRESS_LATCH_EN
  // Latched events: hold until acknowledged; a press arriving while an
  // unacknowledged event is pending is dropped and flagged as an error
  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    err_d   = press_bad;
    if (press_ok && (!valid_q || press_ack)) begin
      valid_d = 1'b1;
      code_d  = rise_code;
    end else begin
      if (valid_q && press_ack) begin
        valid_d = 1'b0;
      end
      if (press_ok) begin
        err_d = 1'b1;
      end
    end
  end
`else
  // Pulse events: one cycle per accepted press, code held until the next one
  always_comb begin
    valid_d = press_ok;
    code_d  = press_ok ? rise_code : code_q;
    err_d   = press_bad;
  end

  logic unused_press_ack;
  assign unused_press_ack = press_ack;
`endif

  // Event, code and error output registers
  always_ff @(posedge CLOCK_50 or negedge rst_int_n) begin
    if (!rst_int_n) begin
      valid_q <= 1'b0;
      code_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      code_q  <= code_d;
      err_q   <= err_d;
    end
  end

  assign press_valid = valid_q;
  assign press_code  = code_q;
  assign multi_err   = err_q;
  assign key_stable  = stable_now;

endmodule

// File: tb/tb_key_input_conditioner.sv
// Directed bench for key_input_conditioner with DEBOUNCE_CYCLES = 4.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 time
// unit after each rising edge. Event edges are counted from the drive point.
module tb_key_input_conditioner;

  localparam int NK = 4;
  localparam int DB = 4;

  logic          clk;
  logic          reset_n;
  logic [NK-1:0] key;
  logic          enable;
  logic          press_ack;
  logic          press_valid;
  logic [1:0]    press_code;
  logic [NK-1:0] key_stable;
  logic          multi_err;

  int passed;
  int total;

  key_input_conditioner #(
    .N_KEYS(NK),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .CLOCK_50   (clk),
    .reset_n    (reset_n),
    .KEY        (key),
    .enable     (enable),
    .press_ack  (press_ack),
    .press_valid(press_valid),
    .press_code (press_code),
    .key_stable (key_stable),
    .multi_err  (multi_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Release every key and let the debouncers settle; releases must not emit
  task automatic release_all();
    key = 4'b1111;
    for (int k = 1; k <= 10; k++) begin
      step();
      total++;
      if (press_valid !== 1'b0)
        $display("[TB] FAIL release_valid edge %0d: got %b want 0", k, press_valid);
      else passed++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    key = 4'b1111;
    enable = 1'b1;
    press_ack = 1'b1;
    step();
    step();
    total++;
    if ({press_valid, press_code, key_stable, multi_err} !== 8'h00)
      $display("[TB] FAIL reset_outputs: got v=%b c=%0d s=%b e=%b want all 0",
               press_valid, press_code, key_stable, multi_err);
    else passed++;
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) step();
    total++;
    if ({press_valid, key_stable, multi_err} !== 6'h00)
      $display("[TB] FAIL idle_after_reset: got v=%b s=%b e=%b want 0",
               press_valid, key_stable, multi_err);
    else passed++;
  endtask

  task automatic test_clean_press();
    key = 4'b1011;
    for (int k = 1; k <= 10; k++) begin
      step();
      total++;
      if (press_valid !== (k == 6))
        $display("[TB] FAIL clean_valid edge %0d: got %b want %b", k, press_valid, (k == 6));
      else passed++;
      if (k == 6) begin
        total++;
        if (press_code !== 2'd2)
          $display("[TB] FAIL clean_code: got %0d want 2", press_code);
        else passed++;
      end
    end
    total++;
    if (key_stable !== 4'b0100)
      $display("[TB] FAIL clean_stable: got %b want 0100", key_stable);
    else passed++;
  endtask

  // KEY[2] still held from the clean press; swap to KEY[1] and reset mid-debounce
  task automatic test_reset_mid_debounce();
    key = 4'b1101;
    step();
    step();
    reset_n = 1'b0;
    #1;
    total++;
    if ({press_valid, press_code, key_stable, multi_err} !== 8'h00)
      $display("[TB] FAIL async_reset: got v=%b c=%0d s=%b e=%b want all 0",
               press_valid, press_code, key_stable, multi_err);
    else passed++;
    step();
    step();
    reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      total++;
      if (press_valid !== (k == 6))
        $display("[TB] FAIL post_reset_valid edge %0d: got %b want %b", k, press_valid, (k == 6));
      else passed++;
      if (k == 6) begin
        total++;
        if (press_code !== 2'd1)
          $display("[TB] FAIL post_reset_code: got %0d want 1", press_code);
        else passed++;
      end
    end
  endtask

  // KEY[0]: low 3 / high 1, three times, then low; one event at edge 18
  task automatic test_bounce();
    for (int s = 0; s < 24; s++) begin
      key = 4'b1111;
      if (s >= 12 || (s % 4) != 3) key[0] = 1'b0;
      step();
      total++;
      if (press_valid !== (s + 1 == 18))
        $display("[TB] FAIL bounce_valid edge %0d: got %b want %b", s + 1, press_valid, (s + 1 == 18));
      else passed++;
      if (s + 1 == 18) begin
        total++;
        if (press_code !== 2'd0)
          $display("[TB] FAIL bounce_code: got %0d want 0", press_code);
        else passed++;
      end
    end
  endtask

  task automatic test_enable_gate();
    enable = 1'b0;
    key = 4'b1101;
    for (int k = 1; k <= 20; k++) begin
      if (k == 11) enable = 1'b1;
      step();
      total++;
      if (press_valid !== 1'b0 || multi_err !== 1'b0)
        $display("[TB] FAIL gated_event edge %0d: got v=%b e=%b want 0 0", k, press_valid, multi_err);
      else passed++;
    end
    total++;
    if (key_stable[1] !== 1'b1)
      $display("[TB] FAIL gated_stable: got %b want 1", key_stable[1]);
    else passed++;
  endtask

  task automatic test_multi_key();
    key = 4'b0110;
    for (int k = 1; k <= 10; k++) begin
      step();
      total++;
      if (press_valid !== 1'b0 || multi_err !== (k == 6))
        $display("[TB] FAIL multi edge %0d: got v=%b e=%b want 0 %b", k, press_valid, multi_err, (k == 6));
      else passed++;
    end
    key = 4'b1110;
    for (int k = 1; k <= 12; k++) begin
      step();
      total++;
      if (press_valid !== 1'b0 || multi_err !== 1'b0)
        $display("[TB] FAIL multi_release edge %0d: got v=%b e=%b want 0 0", k, press_valid, multi_err);
      else passed++;
    end
    total++;
    if (key_stable !== 4'b0001)
      $display("[TB] FAIL multi_stable: got %b want 0001", key_stable);
    else passed++;
  endtask

`ifdef KEY_PRESS_LATCH_EN
  task automatic test_latch();
    int err_pulses;
    err_pulses = 0;
    press_ack = 1'b0;
    key = 4'b0111;
    for (int k = 1; k <= 6; k++) step();
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) key = 4'b0101;
      total++;
      if (press_valid !== 1'b1 || press_code !== 2'd3)
        $display("[TB] FAIL latch_hold cycle %0d: got v=%b c=%0d want 1 3", k, press_valid, press_code);
      else passed++;
      if (multi_err === 1'b1) err_pulses++;
      step();
    end
    total++;
    if (err_pulses !== 1)
      $display("[TB] FAIL latch_err_pulses: got %0d want 1", err_pulses);
    else passed++;
    press_ack = 1'b1;
    step();
    total++;
    if (press_valid !== 1'b0)
      $display("[TB] FAIL latch_ack: got %b want 0", press_valid);
    else passed++;
  endtask
`endif

  initial begin
    passed = 0;
    total = 0;
    reset_n = 1'b0;
    key = 4'b1111;
    enable = 1'b1;
    press_ack = 1'b1;
    test_reset();
    test_clean_press();
    test_reset_mid_debounce();
    release_all();
    test_bounce();
    release_all();
    test_enable_gate();
    release_all();
    test_multi_key();
    release_all();
`ifdef KEY_PRESS_LATCH_EN
    test_latch();
    release_all();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/key_input_conditioner.md
# key_input_conditioner

Conditions the four active-low push-buttons (KEY[3:0]) before they reach the game datapath. Each key is synchronised, debounced and edge-detected, and the block emits one encoded press event per clean single-key press. Presses are only accepted while the controller FSM enables user input. The block sits between the board KEY pins and the datapath's KEY input, replacing the raw button path.

## Interface
Parameters:
- N_KEYS, 4: number of buttons; press_code width is clog2(N_KEYS).
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz); must be ≥ 2.

Ports:
- CLOCK_50  in  1  system clock; the only clock.
- reset_n  in  1  reset, asynchronous and active-low.
- KEY  in  N_KEYS  raw buttons, active-low (0 = pressed), asynchronous to CLOCK_50.
- enable  in  1  from controle; 1 = user input phase, presses accepted.
- press_ack  in  1  consumer acknowledge; used only with KEY_PRESS_LATCH_EN.
- press_valid  out  1  press event present.
- press_code  out  clog2(N_KEYS)  index of the pressed key; valid when press_valid = 1.
- key_stable  out  N_KEYS  debounced levels, active-high (1 = held).
- multi_err  out  1  one-cycle pulse when a press is rejected because more than one key is held.

## Operation
- Reset values for all outputs are 0. Every key's stable state is "released" and all counters are 0.
- Per-key pipeline:
  - A 2-FF synchroniser on the inverted KEY bit produces `sync`.
  - The debounce counter runs as follows:
    - If sync equals stable, the counter clears.
    - Otherwise the counter increments.
    - When the counter reaches DEBOUNCE_CYCLES-1 while sync still differs, stable takes the sync value and the counter clears.
    - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
- Press detection: the key's stable state rises 0→1 (rise_i).
- Event generation happens in the cycle of the rise, evaluated on next-state stable values:
  - If enable = 0, the rise is ignored. No event and no error.
  - If exactly one key's next stable value is 1 and it is the rising key, the block emits an event with press_code equal to that index.
  - If two or more keys have next stable value 1 (simultaneous rises, or a rise while another key is held), there is no event and multi_err pulses for one cycle.
- Releases (1→0) never generate events.
- Deasserting enable mid-debounce does not reset the counters; only the event is suppressed.
- Default mode, macro absent: press_valid is a one-cycle pulse. press_ack is ignored.

## Timing
- A clean KEY edge is followed, DEBOUNCE_CYCLES+2 rising edges later, by the key_stable update and press_valid asserting on the same edge.
- press_code is registered together with press_valid and holds its value until the next event.
- Minimum spacing between two events on the same key is 2·DEBOUNCE_CYCLES cycles: debounced release, then debounced press.
- Asserting reset_n low at any time clears outputs immediately, without waiting for a clock edge.
- Release of reset is synchronous to CLOCK_50 via the design reset synchroniser. A key held through reset is seen as a new press DEBOUNCE_CYCLES+2 cycles after reset release.

## Configuration
- KEY_PRESS_LATCH_EN defined: events are latched.
  - press_valid stays high with press_code stable until a cycle with press_ack = 1.
  - press_valid falls on the following edge.
  - New events arriving while one is pending are dropped, and multi_err pulses for them.
  - An event arriving in the same cycle as press_ack is accepted as the new pending event.
- KEY_PRESS_LATCH_EN absent: pulse mode as in Operation. No handshake logic is present.

## Structure
- Shared package genius_pkg holds:
  - N_KEYS_DEF = 4
  - DEBOUNCE_DEF = 500000
  - typedef key_code_t (2-bit key index)
- The sub-module key_debounce_cell contains one synchroniser, one counter and the stable flop. It is instantiated N_KEYS times via generate.
- The top level does only the one-hot check, encoding and event/latch register.

## Test plan
(All scenarios use DEBOUNCE_CYCLES = 4.)
- Clean press of KEY[2] with enable = 1: KEY 1111→1011 held 10 cycles → press_valid pulses once, 6 edges after the change, with press_code = 2. key_stable becomes 0100.
- Bounce: KEY[0] toggles low 3 cycles and high 1 cycle, repeated 3 times, then stays low → exactly one press_valid with press_code = 0, and no event during the bouncing.
- KEY[1] pressed with enable = 0, then enable = 1 while still held → no press_valid at any point, and key_stable[1] = 1.
- KEY[0] and KEY[3] falling on the same cycle → multi_err pulses once and press_valid stays 0. KEY[3] released while KEY[0] stays held → still no event.
- reset_n asserted low for 2 cycles, 2 cycles into the debounce of KEY[1] → outputs are 0 immediately. After release with KEY[1] still held, press_valid fires with code 1 exactly 6 edges later.
- With KEY_PRESS_LATCH_EN: press key 3, no ack for 20 cycles → press_valid is held with code 3. Press key 1 during that window → multi_err pulses and press_code stays 3. Assert press_ack → press_valid is 0 on the next edge.
